// File: rtl/afw_actuator_seq.sv
// afw_actuator_seq: filters the raw FAN/AC/WIND requests and sequences the
// physical actuator enables with break-before-make, minimum on-time and an
// AC compressor restart lockout.
module afw_actuator_seq #(
    parameter int STABLE_CYC = 4,
    parameter int MIN_ON     = 16,
    parameter int DEAD_CYC   = 8,
    parameter int AC_MIN_OFF = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FAN_REQ,
    input  logic       AC_REQ,
    input  logic       WIND_REQ,
    output logic       FAN_EN,
    output logic       AC_EN,
    output logic       WIND_EN,
    output logic       LOCKOUT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_VENT = 2'b01,
        S_COOL = 2'b10,
        S_DEAD = 2'b11
    } state_t;

    localparam logic [7:0] STABLE8 = 8'(STABLE_CYC);
    localparam logic [7:0] MINON8  = 8'(MIN_ON);
    localparam logic [7:0] DEAD8   = 8'(DEAD_CYC);
    localparam logic [7:0] LOCK8   = 8'(AC_MIN_OFF);

    state_t     sample;
    logic       sample_ok;
    state_t     cand;
    state_t     acc;
    logic [7:0] stab_cnt;
    logic [7:0] stab_next;

    state_t     state;
    state_t     state_next;
    logic       lock_load;
    logic [7:0] dwell;
    logic [7:0] dead;
    logic [7:0] lock;

    // Decode the request triple into a mode; unlisted codes are invalid.
    always_comb begin
        sample    = S_IDLE;
        sample_ok = 1'b0;
        case ({AC_REQ, FAN_REQ, WIND_REQ})
            3'b100: begin sample = S_COOL; sample_ok = 1'b1; end
            3'b011: begin sample = S_VENT; sample_ok = 1'b1; end
            3'b000: begin sample = S_IDLE; sample_ok = 1'b1; end
            default: begin sample = S_IDLE; sample_ok = 1'b0; end
        endcase
    end

    // Run length the current valid sample will have after this edge.
    always_comb begin
        stab_next = 8'd1;
        if (sample == cand) begin
            stab_next = (stab_cnt == STABLE8) ? stab_cnt : stab_cnt + 8'd1;
        end
    end

    // Glitch filter: accept a mode once it has been seen STABLE_CYC times in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= S_IDLE;
            acc      <= S_IDLE;
            stab_cnt <= '0;
        end else if (!sample_ok) begin
            stab_cnt <= '0;
        end else begin
            cand     <= sample;
            stab_cnt <= stab_next;
            if (stab_next == STABLE8) begin
                acc <= sample;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DEAD always separates two active modes.
    always_comb begin
        state_next = state;
        lock_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc == S_VENT) begin
                    state_next = S_VENT;
                end else if (acc == S_COOL && lock == '0) begin
                    state_next = S_COOL;
                end
            end
            S_VENT: begin
                if (acc != S_VENT && dwell == MINON8) begin
                    state_next = S_DEAD;
                end
            end
            S_COOL: begin
                if (acc != S_COOL && dwell == MINON8) begin
                    state_next = S_DEAD;
                    lock_load  = 1'b1;
                end
            end
            S_DEAD: begin
                if (dead == DEAD8 - 8'd1) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Dwell, dead-time and lockout counters; all saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            dead  <= '0;
            lock  <= '0;
        end else begin
            if (state_next != state) begin
                dwell <= '0;
                dead  <= '0;
            end else begin
                if (dwell != MINON8) dwell <= dwell + 8'd1;
                if (dead != DEAD8)   dead  <= dead + 8'd1;
            end
            if (lock_load) begin
                lock <= LOCK8;
            end else if (lock != '0) begin
                lock <= lock - 8'd1;
            end
        end
    end

    // Outputs decode from registered state only, so they cannot glitch.
    always_comb begin
        FAN_EN  = (state == S_VENT);
        WIND_EN = (state == S_VENT);
        AC_EN   = (state == S_COOL);
        LOCKOUT = (lock != '0);
        STATE   = state;
    end

endmodule

// File: tb/tb_afw_actuator_seq.sv
// Randomized bench for afw_actuator_seq against a timestamp-based reference model.
module tb_afw_actuator_seq;

    localparam int STABLE_CYC = 4;
    localparam int MIN_ON     = 16;
    localparam int DEAD_CYC   = 8;
    localparam int AC_MIN_OFF = 64;

    // Request codes {AC,FAN,WIND}
    localparam logic [2:0] R_IDLE = 3'b000;
    localparam logic [2:0] R_VENT = 3'b011;
    localparam logic [2:0] R_COOL = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       FAN_REQ, AC_REQ, WIND_REQ;
    logic       FAN_EN, AC_EN, WIND_EN, LOCKOUT;
    logic [1:0] STATE;

    int errors = 0;
    int checks = 0;

    afw_actuator_seq #(
        .STABLE_CYC(STABLE_CYC),
        .MIN_ON(MIN_ON),
        .DEAD_CYC(DEAD_CYC),
        .AC_MIN_OFF(AC_MIN_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .FAN_REQ(FAN_REQ),
        .AC_REQ(AC_REQ),
        .WIND_REQ(WIND_REQ),
        .FAN_EN(FAN_EN),
        .AC_EN(AC_EN),
        .WIND_EN(WIND_EN),
        .LOCKOUT(LOCKOUT),
        .STATE(STATE)
    );

    always #5 clk = ~clk;

    // Model: modes as ints 0 idle, 1 vent, 2 cool, 3 dead; times are edge numbers.
    int t          = 0;
    int m_mode     = 0;
    int m_start    = 0;
    int m_acc      = 0;
    int m_run_val  = 0;
    int m_run_len  = 0;
    int m_lock_end = -1000;

    function automatic int decode(input logic [2:0] r);
        case (r)
            3'b100:  return 2;
            3'b011:  return 1;
            3'b000:  return 0;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic model_edge();
        int s;
        t++;
        if (rst) begin
            m_mode = 0; m_start = t; m_acc = 0;
            m_run_val = 0; m_run_len = 0; m_lock_end = -1000;
            return;
        end
        // Mode sequencing uses the accepted mode from before this edge.
        case (m_mode)
            0: begin
                if (m_acc == 1) begin
                    m_mode = 1; m_start = t;
                end else if (m_acc == 2 && t > m_lock_end) begin
                    m_mode = 2; m_start = t;
                end
            end
            1, 2: begin
                if (m_acc != m_mode && t - m_start > MIN_ON) begin
                    if (m_mode == 2) m_lock_end = t + AC_MIN_OFF;
                    m_mode = 3; m_start = t;
                end
            end
            default: begin
                if (t - m_start >= DEAD_CYC) begin
                    m_mode = 0; m_start = t;
                end
            end
        endcase
        s = decode({AC_REQ, FAN_REQ, WIND_REQ});
        if (s < 0) begin
            m_run_len = 0;
        end else begin
            m_run_len = (s == m_run_val) ? m_run_len + 1 : 1;
            m_run_val = s;
            if (m_run_len >= STABLE_CYC) m_acc = s;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("FAN_EN",  {7'd0, FAN_EN},  {7'd0, m_mode == 1});
        check("WIND_EN", {7'd0, WIND_EN}, {7'd0, m_mode == 1});
        check("AC_EN",   {7'd0, AC_EN},   {7'd0, m_mode == 2});
        check("LOCKOUT", {7'd0, LOCKOUT}, {7'd0, (m_lock_end - t) > 0});
        check("STATE",   {6'd0, STATE},   8'(m_mode));
        check("overlap", {7'd0, AC_EN & FAN_EN}, 8'd0);
    endtask

    task automatic hold(input logic [2:0] req, input int n);
        {AC_REQ, FAN_REQ, WIND_REQ} = req;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset(input logic [2:0] req, input int n);
        rst = 1'b1;
        hold(req, n);
        rst = 1'b0;
    endtask

    logic [2:0] bad_codes [5] = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b111};

    initial begin
        rst = 1'b1;
        {AC_REQ, FAN_REQ, WIND_REQ} = R_IDLE;
        hold(R_IDLE, 3);
        rst = 1'b0;

        // Directed walk through the headline scenarios.
        hold(R_VENT, 40);
        for (int i = 0; i < 4; i++) begin
            hold(R_VENT, 3);
            hold(R_COOL, 2);
        end
        hold(R_COOL, 40);
        hold(R_IDLE, 10);
        hold(R_COOL, 100);
        hold(R_VENT, 30);
        hold(R_COOL, 6);
        hold(3'b111, 2);
        hold(R_COOL, 30);
        hold(R_IDLE, 25);
        hold(R_VENT, 25);
        hold(R_COOL, 30);
        hold(R_VENT, 22);
        pulse_reset(R_COOL, 1);
        hold(R_COOL, 30);

        // Randomized phases with glitches, invalid codes and occasional resets.
        for (int p = 0; p < 80; p++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                pulse_reset(R_IDLE, int'($urandom_range(1, 3)));
            end else if (kind <= 2) begin
                hold(bad_codes[$urandom_range(0, 4)], int'($urandom_range(1, 4)));
            end else if (kind <= 4) begin
                hold(($urandom_range(0, 1) != 0) ? R_VENT : R_COOL, int'($urandom_range(1, 3)));
            end else begin
                case ($urandom_range(0, 2))
                    0:       hold(R_IDLE, int'($urandom_range(5, 80)));
                    1:       hold(R_VENT, int'($urandom_range(5, 80)));
                    default: hold(R_COOL, int'($urandom_range(5, 80)));
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/afw_actuator_seq.md
# afw_actuator_seq

Sequencer sitting directly downstream of the AC/fan/window decision logic. It takes the raw combinational FAN/AC/WIND requests, filters glitches, and drives the physical actuator enables. It guarantees break-before-make between cooling and venting, minimum on-time per mode, and a compressor restart lockout for the AC.

## Interface
Parameters:
- STABLE_CYC, 4: consecutive identical valid request samples required before a mode is accepted (1..255)
- MIN_ON, 16: minimum cycles an active mode (VENT/COOL) is held (1..255)
- DEAD_CYC, 8: cycles all actuators stay off between modes (1..255)
- AC_MIN_OFF, 64: cycles the AC is locked out after it turns off (1..255)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- FAN_REQ  in  1  fan request from decision logic
- AC_REQ  in  1  AC request from decision logic
- WIND_REQ  in  1  window request from decision logic
- FAN_EN  out  1  fan actuator enable
- AC_EN  out  1  AC actuator enable
- WIND_EN  out  1  window actuator enable
- LOCKOUT  out  1  high while the AC restart lockout is running
- STATE  out  2  debug: 00 IDLE, 01 VENT, 10 COOL, 11 DEAD

## Operation
- Request decode {AC,FAN,WIND}: 100 = COOL; 011 = VENT; 000 = IDLE; any other combination = invalid.
- Filter registers: cand (2b), stab_cnt (8b), acc (2b, accepted mode).
  - Invalid sample: stab_cnt <= 0; cand and acc unchanged.
  - Valid sample != cand: cand <= sample, stab_cnt <= 1.
  - Valid sample == cand: stab_cnt increments, saturating at STABLE_CYC.
  - On the edge where the count of consecutive samples reaches STABLE_CYC: acc <= cand.
- FSM states: IDLE, VENT, COOL, DEAD. Counters: dwell (8b), dead (8b), lock (8b); all saturating, never wrap.
- IDLE:
  - acc==VENT -> VENT.
  - acc==COOL and lock==0 -> COOL.
  - acc==COOL and lock!=0 -> stay IDLE.
- VENT / COOL:
  - dwell clears on entry and increments, saturating at MIN_ON.
  - acc != current mode and dwell==MIN_ON -> DEAD. Otherwise hold.
- COOL -> DEAD edge also loads lock <= AC_MIN_OFF.
- DEAD: occupies exactly DEAD_CYC cycles, then -> IDLE. acc changes during DEAD are not acted on until IDLE re-evaluates.
- lock decrements by 1 every cycle while nonzero, in every state. LOCKOUT = (lock != 0).
- Outputs decode from the state register only, so they are glitch-free:
  - VENT: FAN_EN = WIND_EN = 1, AC_EN = 0.
  - COOL: AC_EN = 1, FAN_EN = WIND_EN = 0.
  - IDLE / DEAD: all enables 0.
  - AC_EN and FAN_EN are never high in the same cycle.

## Timing
- Reset values: state IDLE, cand = acc = IDLE, all counters 0, FAN_EN = AC_EN = WIND_EN = LOCKOUT = 0, STATE = 00.
- Reset asserted mid-operation: all of the above take effect on the next edge. The lockout is cleared too.
- IDLE->VENT latency: request sampled at edges 1..STABLE_CYC; acc updates at edge STABLE_CYC; FAN_EN rises after edge STABLE_CYC+1 (5 edges at defaults).
- VENT->COOL with MIN_ON already met and no lockout:
  - DEAD entered at edge STABLE_CYC+1.
  - IDLE entered after DEAD_CYC cycles.
  - COOL entered 1 cycle later.
  - AC_EN rises STABLE_CYC+DEAD_CYC+2 edges after the request changes (14 at defaults).
- acc changes before dwell==MIN_ON: exit to DEAD occurs on the edge after dwell reaches MIN_ON, provided acc still differs.
- acc returns to the current mode before MIN_ON is reached: no transition.
- COOL requested while lock != 0: wait in IDLE with all enables off; COOL entered on the edge after lock reaches 0.
- A request glitch shorter than STABLE_CYC samples has no effect on acc or the outputs.

## Test plan
- Reset, then hold VENT (011) -> FAN_EN/WIND_EN rise at edge 5, STATE=01, AC_EN stays 0.
- VENT for 3 cycles interleaved with COOL for 2 cycles -> acc never changes; outputs stay at their prior values.
- Hold VENT 40 cycles, then COOL -> FAN/WIND drop at edge 5 after the change; AC_EN rises at edge 14; no overlap.
- COOL 40 cycles -> IDLE -> COOL: LOCKOUT goes high for 64 cycles after COOL exits; AC_EN re-rises only on the edge after LOCKOUT falls.
- VENT accepted, COOL requested at VENT dwell 2 -> DEAD entered only once dwell==16; invalid code 111 during hold is ignored.
- Assert rst during DEAD with LOCKOUT high -> next edge all outputs 0, STATE=00; lock cleared, so a COOL request enters COOL 5 edges after rst deasserts.
